// File: rtl/jkff_drv_pkg.sv
// Shared types and JK excitation codes for the JK flip-flop bank driver.
package jkff_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    // {J,K} codes applied to one flip-flop
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    // Excitation for one bit moving from q to t; changing bits either toggle
    // or use a dedicated set/reset code depending on toggle_mode.
    function automatic logic [1:0] jk_code(input logic q, input logic t,
                                           input logic toggle_mode);
        logic [1:0] code;
        code = HOLD;
        if (!q && t) begin
            code = toggle_mode ? TGL : SET;
        end else if (q && !t) begin
            code = toggle_mode ? TGL : RST;
        end
        return code;
    endfunction

endpackage

// File: rtl/jkff_bank_driver_jk_excite.sv
// Combinational per-bit JK excitation: (current Q, target) -> (J, K).
module jk_excite
    import jkff_drv_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter bit          TOGGLE_MODE = 1'b1
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);

    // Map every bit independently through the shared excitation table
    always_comb begin
        j_o = '0;
        k_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            {j_o[i], k_o[i]} = jk_code(q_i[i], target_i[i], TOGGLE_MODE);
        end
    end

endmodule

// File: rtl/jkff_bank_driver.sv
// Drives J/K/E of an enabled JK flip-flop bank towards a target word,
// verifies the fed-back Q and retries a bounded number of times.
module jkff_bank_driver
    import jkff_drv_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TOGGLE_MODE = 1,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             e_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             e_q, e_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // One excitation unit serves both the first attempt (fresh tgt_data in
    // IDLE) and retries (latched target in CHECK).
    assign exc_tgt = (state_q == IDLE) ? tgt_data : target_q;

    jk_excite #(
        .WIDTH       (WIDTH),
        .TOGGLE_MODE (TOGGLE_MODE != 0)
    ) u_excite (
        .q_i      (q_fb),
        .target_i (exc_tgt),
        .j_o      (exc_j),
        .k_o      (exc_k)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        j_d      = '0;
        k_d      = '0;
        e_d      = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    target_d = tgt_data;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    e_d      = 1'b1;
                    retry_d  = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + RW'(1);
                    j_d     = exc_j;
                    k_d     = exc_k;
                    e_d     = 1'b1;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            retry_q  <= '0;
            j_q      <= '0;
            k_q      <= '0;
            e_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            j_q      <= j_d;
            k_q      <= k_d;
            e_q      <= e_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign e_out     = e_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jkff_bank_driver.sv
// Self-checking bench: two drivers (toggle and set/reset excitation), each
// closing the loop through a behavioural JK bank model.
module tb_jkff_bank_driver;

    localparam int W     = 4;
    localparam int RETRY = 2;

    logic clk;
    logic rst_n;

    logic         tgt_valid [2];
    logic         tgt_ready [2];
    logic [W-1:0] tgt_data  [2];
    logic [W-1:0] j_out     [2];
    logic [W-1:0] k_out     [2];
    logic         e_out     [2];
    logic         busy      [2];
    logic         done      [2];
    logic         err       [2];

    logic [W-1:0] bank_q     [2];
    logic         preset_en  [2];
    logic [W-1:0] preset_val [2];
    logic         stuck      [2];

    int n_cmp;
    int n_bad;

    jkff_bank_driver #(.WIDTH(W), .TOGGLE_MODE(1), .MAX_RETRY(RETRY)) u_dut_tgl (
        .clk(clk), .reset(rst_n),
        .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]), .tgt_data(tgt_data[0]),
        .q_fb(bank_q[0]), .j_out(j_out[0]), .k_out(k_out[0]), .e_out(e_out[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    jkff_bank_driver #(.WIDTH(W), .TOGGLE_MODE(0), .MAX_RETRY(RETRY)) u_dut_sr (
        .clk(clk), .reset(rst_n),
        .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]), .tgt_data(tgt_data[1]),
        .q_fb(bank_q[1]), .j_out(j_out[1]), .k_out(k_out[1]), .e_out(e_out[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural enabled JK bank: Q+ = J&~Q | ~K&Q when E is high
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preset_en[i])
                bank_q[i] <= preset_val[i];
            else if (e_out[i] && !stuck[i])
                bank_q[i] <= (j_out[i] & ~bank_q[i]) | (~k_out[i] & bank_q[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference excitation from the transition rules: a changing bit gets J
    // when it must rise and K when it must fall; toggle mode asserts both.
    function automatic logic [W-1:0] ref_j(input logic [W-1:0] q, input logic [W-1:0] t, input bit tm);
        logic [W-1:0] ch;
        ch = q ^ t;
        return tm ? ch : (ch & t);
    endfunction

    function automatic logic [W-1:0] ref_k(input logic [W-1:0] q, input logic [W-1:0] t, input bit tm);
        logic [W-1:0] ch;
        ch = q ^ t;
        return tm ? ch : (ch & ~t);
    endfunction

    // Runs one transaction on driver idx. Entered at a negedge in IDLE,
    // returns at the negedge of the done/err pulse cycle.
    task automatic do_txn(input int idx, input bit do_preset, input logic [W-1:0] q0,
                          input logic [W-1:0] tgt, input bit stuck_bank);
        logic [W-1:0] qs, ej, ek;
        bit tm;
        int pulses, errs;
        bit done_seen;
        tm = (idx == 0);
        if (do_preset) begin
            preset_en[idx]  = 1'b1;
            preset_val[idx] = q0;
            @(negedge clk);
            preset_en[idx]  = 1'b0;
        end
        qs = bank_q[idx];
        stuck[idx] = stuck_bank;
        ej = ref_j(qs, tgt, tm);
        ek = ref_k(qs, tgt, tm);
        chk("ready_idle", tgt_ready[idx], 1);
        tgt_valid[idx] = 1'b1;
        tgt_data[idx]  = tgt;
        @(negedge clk);
        tgt_valid[idx] = 1'b0;
        tgt_data[idx]  = $urandom();
        chk("drv_e", e_out[idx], 1);
        chk("drv_j", j_out[idx], ej);
        chk("drv_k", k_out[idx], ek);
        chk("drv_busy", busy[idx], 1);
        chk("drv_ready", tgt_ready[idx], 0);
        chk("drv_nodone", {done[idx], err[idx]}, 0);
        if (!stuck_bank) begin
            @(negedge clk);
            chk("chk_e", e_out[idx], 0);
            chk("chk_jk", {j_out[idx], k_out[idx]}, 0);
            chk("chk_busy", busy[idx], 1);
            chk("chk_q", bank_q[idx], tgt);
            chk("chk_nopulse", {done[idx], err[idx]}, 0);
            @(negedge clk);
            chk("done", done[idx], 1);
            chk("done_noerr", err[idx], 0);
            chk("done_ready", tgt_ready[idx], 1);
            chk("done_idle", busy[idx], 0);
        end else begin
            pulses = 1;
            errs = 0;
            done_seen = 0;
            for (int c = 0; c < 20 && errs == 0; c++) begin
                @(negedge clk);
                if (e_out[idx]) begin
                    pulses++;
                    chk("retry_j", j_out[idx], ej);
                    chk("retry_k", k_out[idx], ek);
                end
                if (done[idx]) done_seen = 1;
                if (err[idx]) errs++;
            end
            chk("retry_pulses", pulses, RETRY + 1);
            chk("err_seen", errs, 1);
            chk("err_nodone", done_seen, 0);
            chk("err_ready", tgt_ready[idx], 1);
            chk("err_q_unchanged", bank_q[idx], qs);
            stuck[idx] = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tgt_valid[i]  = 1'b0;
            tgt_data[i]   = '0;
            preset_en[i]  = 1'b0;
            preset_val[i] = '0;
            stuck[i]      = 1'b0;
        end

        // 1: reset state, during and after reset
        repeat (3) @(negedge clk);
        chk("rst_e", e_out[0], 0);
        chk("rst_ready", tgt_ready[1], 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_jk", {j_out[0], k_out[0]}, 0);
        chk("rel_e", e_out[0], 0);
        chk("rel_pulse", {done[0], err[0]}, 0);
        chk("rel_busy", busy[0], 0);
        chk("rel_ready", tgt_ready[0], 1);

        // 2: toggle excitation 0000 -> 1010
        do_txn(0, 1, 4'b0000, 4'b1010, 0);
        @(negedge clk);
        // 3: all-equal target still drives with J=K=0
        do_txn(0, 0, 4'b0000, 4'b1010, 0);
        @(negedge clk);
        // 4: set/reset excitation 1100 -> 0110, then back-to-back in pulse cycle
        do_txn(1, 1, 4'b1100, 4'b0110, 0);
        do_txn(1, 0, 4'b0000, 4'b1001, 0);
        @(negedge clk);
        // 5: bank ignores enable -> retries then err
        do_txn(0, 1, 4'b0000, 4'b1111, 1);
        @(negedge clk);
        chk("err_width", err[0], 0);

        // 6: reset during DRIVE
        preset_en[0] = 1'b1;
        preset_val[0] = 4'b0000;
        @(negedge clk);
        preset_en[0] = 1'b0;
        tgt_valid[0] = 1'b1;
        tgt_data[0]  = 4'b0101;
        @(negedge clk);
        tgt_valid[0] = 1'b0;
        chk("rstmid_drive_e", e_out[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_e", e_out[0], 0);
        chk("rstmid_jk", {j_out[0], k_out[0]}, 0);
        chk("rstmid_busy", busy[0], 0);
        chk("rstmid_ready", tgt_ready[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_q", bank_q[0], 4'b0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_nopulse", {done[0], err[0]}, 0);
        end
        do_txn(0, 0, 4'b0000, 4'b0001, 0);
        @(negedge clk);

        // Randomized transactions on both drivers
        for (int n = 0; n < 24; n++) begin
            do_txn(n % 2, ($urandom_range(0, 1) == 1), W'($urandom()), W'($urandom()),
                   ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
